// File: rtl/param_parity_s_reg.sv
// G-word parity generate/check with sticky alarm, S register, and edit-channel sequencer.
// Define PAR_ALARM_COUNT_EN to raise the alarm only after ALARM_THRESH consecutive parity errors.
module param_parity_s_reg #(
  parameter int unsigned GW           = 15,
  parameter int unsigned SW           = 12,
  parameter int unsigned NCH          = 4,
  parameter int unsigned ODD          = 1,
  parameter int unsigned ALARM_THRESH = 2
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic [GW-1:0]   g_data,
  input  logic            g_par,
  input  logic            g_chk,
  input  logic            gen_req,
  output logic            gen_par,
  output logic            geqzro,
  input  logic [SW-1:0]   wl,
  input  logic            wsg,
  input  logic            csg,
  output logic [SW-1:0]   s_q,
  output logic [SW-1:0]   s_n,
  input  logic [NCH-1:0]  edit_hit,
  input  logic            t02,
  input  logic            t12a,
  output logic [NCH-1:0]  edit_pls,
  output logic            ginh,
  output logic            edit_done,
  input  logic            alarm_clr,
  output logic            par_alarm
);

  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CNTW = 4;

  typedef enum logic {IDLE, ACTIVE} edit_state_e;

  // Threshold must fit the 4-bit saturating counter.
  if (ALARM_THRESH < 1 || ALARM_THRESH > 15) begin : g_thresh_range
    $error("ALARM_THRESH must be in 1..15");
  end

  logic par_c;
  logic err_c;

  assign par_c  = (^g_data) ^ (ODD != 0);
  assign err_c  = g_chk && (g_par != par_c);
  assign geqzro = (g_data == '0);

  // Parity generator output register.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      gen_par <= 1'b0;
    end else if (gen_req) begin
      gen_par <= par_c;
    end
  end

  // S register; write beats clear, complement registered alongside.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      s_q <= '0;
      s_n <= '1;
    end else if (wsg) begin
      s_q <= wl;
      s_n <= ~wl;
    end else if (csg) begin
      s_q <= '0;
      s_n <= '1;
    end
  end

`ifdef PAR_ALARM_COUNT_EN
  localparam logic [CNTW-1:0] THRESH = CNTW'(ALARM_THRESH);

  logic [CNTW-1:0] err_cnt_q;
  logic [CNTW-1:0] err_cnt_inc_c;

  assign err_cnt_inc_c = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNTW'(1);

  // Consecutive-error counter; clear has priority over a same-cycle error.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      err_cnt_q <= '0;
      par_alarm <= 1'b0;
    end else if (alarm_clr) begin
      err_cnt_q <= '0;
      par_alarm <= 1'b0;
    end else if (g_chk) begin
      if (err_c) begin
        err_cnt_q <= err_cnt_inc_c;
        if (err_cnt_inc_c >= THRESH) begin
          par_alarm <= 1'b1;
        end
      end else begin
        err_cnt_q <= '0;
      end
    end
  end
`else
  // Any single parity error latches the alarm.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      par_alarm <= 1'b0;
    end else if (alarm_clr) begin
      par_alarm <= 1'b0;
    end else if (err_c) begin
      par_alarm <= 1'b1;
    end
  end
`endif

  edit_state_e      state_q, state_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [CHW-1:0]   hit_ch;
  logic [NCH-1:0]   pls_d;
  logic             ginh_d;
  logic             done_d;

  // Edit sequencer state and registered outputs.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      edit_pls  <= '0;
      ginh      <= 1'b0;
      edit_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      edit_pls  <= pls_d;
      ginh      <= ginh_d;
      edit_done <= done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    pls_d   = '0;
    hit_ch  = '0;
    // Descending scan leaves the lowest-index hit.
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (edit_hit[i]) hit_ch = CHW'(i);
    end
    case (state_q)
      IDLE: begin
        if (t02 && (|edit_hit)) begin
          state_d = ACTIVE;
          ch_d    = hit_ch;
        end
      end
      ACTIVE: begin
        if (t12a) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ACTIVE) pls_d[ch_d] = 1'b1;
    ginh_d = (state_d == ACTIVE);
  end

endmodule

// File: tb/tb_param_parity_s_reg.sv
// Directed bench for param_parity_s_reg: vector table for parity/S register, hand sequences for alarm and edit FSM.
module tb_param_parity_s_reg;

  localparam int unsigned GW  = 15;
  localparam int unsigned SW  = 12;
  localparam int unsigned NCH = 4;

  logic           SIM_CLK = 1'b0;
  logic           SIM_RST;
  logic [GW-1:0]  g_data;
  logic           g_par, g_chk, gen_req, gen_par, geqzro;
  logic [SW-1:0]  wl, s_q, s_n;
  logic           wsg, csg;
  logic [NCH-1:0] edit_hit, edit_pls;
  logic           t02, t12a, ginh, edit_done, alarm_clr, par_alarm;

  int n_cmp = 0;
  int n_bad = 0;

  param_parity_s_reg dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .g_data(g_data), .g_par(g_par), .g_chk(g_chk),
    .gen_req(gen_req), .gen_par(gen_par), .geqzro(geqzro),
    .wl(wl), .wsg(wsg), .csg(csg), .s_q(s_q), .s_n(s_n),
    .edit_hit(edit_hit), .t02(t02), .t12a(t12a),
    .edit_pls(edit_pls), .ginh(ginh), .edit_done(edit_done),
    .alarm_clr(alarm_clr), .par_alarm(par_alarm)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  typedef struct {
    logic [GW-1:0] g_data;
    logic          gen_req;
    logic [SW-1:0] wl;
    logic          wsg;
    logic          csg;
    logic          exp_geqzro;
    logic          exp_gen_par;
    logic [SW-1:0] exp_s_q;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_edit(input string name, input logic [NCH-1:0] pls, input logic gi, input logic dn);
    chk({name, ".edit_pls"}, 32'(edit_pls), 32'(pls));
    chk({name, ".ginh"}, 32'(ginh), 32'(gi));
    chk({name, ".edit_done"}, 32'(edit_done), 32'(dn));
  endtask

  initial begin
    // Odd parity: gen_par = ~^g_data
    vecs[0] = '{15'h0000, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b1, 1'b1, 12'hABC};
    vecs[1] = '{15'h0001, 1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{15'h7FFF, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123};
    vecs[3] = '{15'h0003, 1'b1, 12'h456, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123};
    vecs[4] = '{15'h4000, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123};
    vecs[5] = '{15'h7FFF, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF};
    vecs[6] = '{15'h5555, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000};

    // Reset with every strobe active must still clear everything.
    SIM_RST = 1'b1; g_data = '0; g_par = 1'b1; g_chk = 1'b1; gen_req = 1'b1;
    wl = 12'hABC; wsg = 1'b1; csg = 1'b0; edit_hit = 4'b0001; t02 = 1'b1; t12a = 1'b0;
    alarm_clr = 1'b0;
    tick();
    tick();
    chk("rst.s_q", 32'(s_q), 32'h000);
    chk("rst.s_n", 32'(s_n), 32'hFFF);
    chk("rst.gen_par", 32'(gen_par), 32'h0);
    chk("rst.par_alarm", 32'(par_alarm), 32'h0);
    chk_edit("rst", 4'b0000, 1'b0, 1'b0);

    SIM_RST = 1'b0; g_chk = 1'b0; g_par = 1'b0; gen_req = 1'b0; wsg = 1'b0;
    edit_hit = '0; t02 = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      g_data = vecs[i].g_data; gen_req = vecs[i].gen_req;
      wl = vecs[i].wl; wsg = vecs[i].wsg; csg = vecs[i].csg;
      #1;
      chk($sformatf("vec%0d.geqzro", i), 32'(geqzro), 32'(vecs[i].exp_geqzro));
      tick();
      chk($sformatf("vec%0d.gen_par", i), 32'(gen_par), 32'(vecs[i].exp_gen_par));
      chk($sformatf("vec%0d.s_q", i), 32'(s_q), 32'(vecs[i].exp_s_q));
      chk($sformatf("vec%0d.s_n", i), 32'(s_n), 32'(SW'(~vecs[i].exp_s_q)));
    end
    gen_req = 1'b0; wsg = 1'b0; csg = 1'b0;

    // Parity alarm: g_data=1 has odd parity 0.
    g_data = 15'h0001; g_par = 1'b0; g_chk = 1'b1;
    tick(); chk("alm.pass1", 32'(par_alarm), 32'h0);
    tick(); chk("alm.pass2", 32'(par_alarm), 32'h0);
    g_par = 1'b1;
`ifdef PAR_ALARM_COUNT_EN
    tick(); chk("alm.err1", 32'(par_alarm), 32'h0);
    tick(); chk("alm.err2", 32'(par_alarm), 32'h1);
`else
    tick(); chk("alm.err1", 32'(par_alarm), 32'h1);
`endif
    g_chk = 1'b0;
    tick(); chk("alm.sticky", 32'(par_alarm), 32'h1);
    g_par = 1'b0; g_chk = 1'b1;
    tick(); chk("alm.sticky_pass", 32'(par_alarm), 32'h1);
    g_par = 1'b1; alarm_clr = 1'b1;
    tick(); chk("alm.clr_wins", 32'(par_alarm), 32'h0);
    alarm_clr = 1'b0;
`ifdef PAR_ALARM_COUNT_EN
    // Error / pass / error never reaches 2 consecutive.
    tick(); chk("alm.e", 32'(par_alarm), 32'h0);
    g_par = 1'b0;
    tick(); chk("alm.ep", 32'(par_alarm), 32'h0);
    g_par = 1'b1;
    tick(); chk("alm.epe", 32'(par_alarm), 32'h0);
    tick(); chk("alm.epee", 32'(par_alarm), 32'h1);
`else
    g_chk = 1'b0;
    tick(); chk("alm.idle_after_clr", 32'(par_alarm), 32'h0);
    g_chk = 1'b1;
    tick(); chk("alm.reerr", 32'(par_alarm), 32'h1);
`endif
    g_chk = 1'b0; alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;

    // t02 without a hit stays idle.
    t02 = 1'b1; edit_hit = 4'b0000;
    tick(); chk_edit("nohit", 4'b0000, 1'b0, 1'b0);

    // Lowest set hit selects channel 1; mid-edit t02 ignored.
    edit_hit = 4'b0110;
    tick(); chk_edit("ed.start", 4'b0010, 1'b1, 1'b0);
    t02 = 1'b0; edit_hit = '0;
    tick(); chk_edit("ed.hold", 4'b0010, 1'b1, 1'b0);
    t02 = 1'b1; edit_hit = 4'b1000;
    tick(); chk_edit("ed.t02mid", 4'b0010, 1'b1, 1'b0);
    t02 = 1'b0; edit_hit = '0; t12a = 1'b1;
    tick(); chk_edit("ed.end", 4'b0000, 1'b0, 1'b1);
    t12a = 1'b0;
    tick(); chk_edit("ed.done_once", 4'b0000, 1'b0, 1'b0);

    // t02 and t12a together in IDLE: enter and wait for a later t12a.
    t02 = 1'b1; t12a = 1'b1; edit_hit = 4'b0001;
    tick(); chk_edit("ed2.start", 4'b0001, 1'b1, 1'b0);
    t02 = 1'b0; t12a = 1'b0; edit_hit = '0;
    tick(); chk_edit("ed2.wait", 4'b0001, 1'b1, 1'b0);
    t12a = 1'b1;
    tick(); chk_edit("ed2.end", 4'b0000, 1'b0, 1'b1);
    t12a = 1'b0;
    tick();

    // Reset mid-edit aborts without edit_done.
    t02 = 1'b1; edit_hit = 4'b1000;
    tick(); chk_edit("ed3.start", 4'b1000, 1'b1, 1'b0);
    t02 = 1'b0; edit_hit = '0; SIM_RST = 1'b1;
    tick(); chk_edit("ed3.rst", 4'b0000, 1'b0, 1'b0);
    chk("ed3.rst.s_q", 32'(s_q), 32'h000);
    SIM_RST = 1'b0;
    tick(); chk_edit("ed3.after", 4'b0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_parity_s_reg.md
PARAM_PARITY_S_REG -- requirements
Module: param_parity_s_reg

Interface
REQ-001 Parameter GW, default 15: width of the G data word, excluding the parity bit.
REQ-002 Parameter SW, default 12: width of the S register.
REQ-003 Parameter NCH, default 4: number of edit channels.
REQ-004 Parameter ODD, default 1: 1 = odd parity, 0 = even parity.
REQ-005 Parameter ALARM_THRESH, default 2: number of consecutive parity errors that raise the alarm (range 1..15).
REQ-006 Port SIM_CLK, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-007 Port SIM_RST, input, 1 bit: synchronous, active-high reset.
REQ-008 Ports g_data (input, GW bits) and g_par (input, 1 bit): G word and its stored parity bit.
REQ-009 Port g_chk, input, 1 bit: check strobe for g_data/g_par.
REQ-010 Port gen_req, input, 1 bit: parity-generate strobe.
REQ-011 Port gen_par, output, 1 bit: generated parity bit.
REQ-012 Port geqzro, output, 1 bit: asserted when g_data is all zeros.
REQ-013 Ports wl (input, SW bits), wsg (input, 1 bit), csg (input, 1 bit): write-bus data, S write strobe, S clear strobe.
REQ-014 Ports s_q (output, SW bits) and s_n (output, SW bits): S register and its complement.
REQ-015 Ports edit_hit (input, NCH bits), t02 (input, 1 bit), t12a (input, 1 bit): edit-address decode, edit start timing pulse, edit end timing pulse.
REQ-016 Ports edit_pls (output, NCH bits), ginh (output, 1 bit), edit_done (output, 1 bit): edit channel pulses, G inhibit, edit-complete pulse.
REQ-017 Ports alarm_clr (input, 1 bit) and par_alarm (output, 1 bit): alarm clear and sticky parity alarm.

Function
REQ-018 Parity is defined as the XOR of all g_data bits, inverted when ODD=1.
REQ-019 On any cycle with gen_req high, gen_par SHALL take the parity of g_data on the next edge; gen_par holds its value otherwise.
REQ-020 geqzro is combinational and has no latency.
REQ-021 A check occurs on any cycle with g_chk high; the check is an error when g_par differs from the computed parity.
REQ-022 Each error check increments a saturating consecutive-error counter; each passing check clears the counter to 0.
REQ-023 par_alarm SHALL set on the edge at which the counter reaches ALARM_THRESH, with 1-cycle latency from the offending g_chk.
REQ-024 par_alarm is sticky until alarm_clr or reset; alarm_clr also zeroes the counter.
REQ-025 If alarm_clr and an error check occur in the same cycle, the clear wins and the counter becomes 0.
REQ-026 S register update priority: wsg loads wl; otherwise csg loads 0; otherwise S holds.
REQ-027 With wsg and csg both high, S takes wl (clear-then-write semantics).
REQ-028 s_n is always the bitwise inverse of s_q.
REQ-029 Edit FSM in IDLE: a cycle with t02 high and any edit_hit bit high moves it to ACTIVE(ch), where ch is the lowest-index set bit of edit_hit; otherwise it stays IDLE.
REQ-030 In ACTIVE(ch): edit_pls[ch] and ginh are high and all other edit_pls bits are low.
REQ-031 In ACTIVE(ch), t02 and edit_hit are ignored.
REQ-032 In ACTIVE(ch), the cycle with t12a high is the last active cycle; the FSM returns to IDLE on the next edge and edit_done pulses high for exactly one cycle.
REQ-033 t02 and t12a high in the same cycle while IDLE: the FSM enters ACTIVE and waits for a later t12a.
REQ-034 In IDLE, edit_pls is 0, ginh is 0 and edit_done is 0.

Reset
REQ-035 While SIM_RST is high at a clock edge: S=0, gen_par=0, counter=0, par_alarm=0, FSM=IDLE, edit_pls=0, ginh=0, edit_done=0.
REQ-036 Reset overrides every simultaneous strobe.
REQ-037 Reset during ACTIVE aborts the edit without an edit_done pulse.

Configuration
REQ-038 The macro PAR_ALARM_COUNT_EN controls the consecutive-error counter.
REQ-039 With PAR_ALARM_COUNT_EN defined, the counter and ALARM_THRESH behave as specified in REQ-022 to REQ-025.
REQ-040 Without PAR_ALARM_COUNT_EN, no counter is built, ALARM_THRESH is ignored, and the first error check sets par_alarm.

Verification
REQ-041 Defaults, g_data=15'h0001, g_par=0, g_chk twice -> par_alarm=0 (odd parity is 0, both checks pass); then g_par=1 twice -> par_alarm=1 one cycle after the second check.
REQ-042 Error, pass, error sequence with threshold 2 -> par_alarm stays 0; alarm_clr together with an error -> par_alarm=0 and counter=0.
REQ-043 wl=12'hABC with wsg and csg both high -> s_q=12'hABC, s_n=12'h543; next cycle csg alone -> s_q=0.
REQ-044 edit_hit=4'b0110 with t02 -> edit_pls=4'b0010 and ginh=1 until the t12a cycle; edit_done=1 for one cycle after it; t02 pulse mid-edit has no effect.
REQ-045 SIM_RST asserted mid-edit -> all outputs 0 next cycle and no edit_done pulse.
REQ-046 Build without PAR_ALARM_COUNT_EN, single error check -> par_alarm=1 after 1 cycle.
